// File: rtl/pipe_ctrl.sv
// Pipeline controller for the RV32I core.
// Sits between ex and the pc_reg / if_id / id_ex stages. It releases fetch
// after a fixed boot window and turns taken jumps into pc loads with flushes.
// While ex or the bus stalls, it freezes the front of the pipe. The first
// jump seen during a stall is remembered and issued after the stall clears.
// A watchdog pulses once when a single stall episode runs too long.
//
// Outputs other than hold_timeout_o and state_o are combinational.
// This lets a jump or hold take effect in the same cycle that ex raises it.

module pipe_ctrl #(
  parameter int BOOT_CYCLES  = 4,
  parameter int HOLD_TIMEOUT = 256,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_ex_i,
  input  logic        hold_bus_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        hold_timeout_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Counter reference points, pre-sized so comparisons stay width-clean
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(HOLD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(HOLD_TIMEOUT);
  localparam logic             TO_EN     = (HOLD_TIMEOUT != 0);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic        pend_en_r;
  logic        pend_en_nxt_s;
  logic [31:0] pend_addr_r;
  logic [31:0] pend_addr_nxt_s;
  logic        hold_timeout_r;
  logic        hold_timeout_nxt_s;
  logic        hold_s;

  // Either stall source freezes the front of the pipeline
  assign hold_s = hold_ex_i | hold_bus_i;

  // Debug view of the controller phase and the registered watchdog pulse
  assign state_o        = state_r;
  assign hold_timeout_o = hold_timeout_r;

  // State, counter, pending-jump and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_BOOT;
      cnt_r          <= CNT_ZERO;
      pend_en_r      <= 1'b0;
      pend_addr_r    <= 32'h0000_0000;
      hold_timeout_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      pend_en_r      <= pend_en_nxt_s;
      pend_addr_r    <= pend_addr_nxt_s;
      hold_timeout_r <= hold_timeout_nxt_s;
    end
  end

  // Next-state logic and the combinational pipeline controls
  always_comb begin
    state_nxt_s        = state_r;
    cnt_nxt_s          = cnt_r;
    pend_en_nxt_s      = pend_en_r;
    pend_addr_nxt_s    = pend_addr_r;
    hold_timeout_nxt_s = 1'b0;
    jump_en_o          = 1'b0;
    jump_addr_o        = 32'h0000_0000;
    hold_pc_o          = 1'b0;
    hold_if_id_o       = 1'b0;
    hold_id_ex_o       = 1'b0;
    flush_if_id_o      = 1'b0;
    flush_id_ex_o      = 1'b0;

    case (state_r)
      ST_BOOT: begin
        // Fetch stays parked and the decode stages are filled with NOPs.
        // ex is not trusted yet, so its requests are ignored here.
        hold_pc_o     = 1'b1;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        if (cnt_r == BOOT_LAST) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end

      ST_RUN: begin
        if (hold_s) begin
          // A stall blocks the jump. Remember it so it can run after the stall.
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
          if (jump_en_i) begin
            pend_en_nxt_s   = 1'b1;
            pend_addr_nxt_s = jump_addr_i;
          end else begin
            pend_en_nxt_s = pend_en_r;
          end
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = CNT_ONE;
        end else if (jump_en_i) begin
          jump_en_o     = 1'b1;
          jump_addr_o   = jump_addr_i;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end

      ST_HOLD: begin
        if (hold_s) begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
          // Only the oldest redirect matters. Later ones come from
          // instructions that the redirect will squash anyway.
          if (jump_en_i && !pend_en_r) begin
            pend_en_nxt_s   = 1'b1;
            pend_addr_nxt_s = jump_addr_i;
          end else begin
            pend_en_nxt_s = pend_en_r;
          end
          // The count saturates, so the match below fires once per episode.
          if (cnt_r < TO_MAX) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_nxt_s = cnt_r;
          end
          if (TO_EN && (cnt_r == TO_LAST)) begin
            hold_timeout_nxt_s = 1'b1;
          end else begin
            hold_timeout_nxt_s = 1'b0;
          end
        end else begin
          cnt_nxt_s = CNT_ZERO;
          if (pend_en_r) begin
            // Spend one quiet cycle, then issue the deferred redirect.
            state_nxt_s = ST_FLUSH;
          end else if (jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            state_nxt_s   = ST_RUN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end

      ST_FLUSH: begin
        if (hold_s) begin
          // A new stall beats the redirect. Keep the pending jump and retry later.
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
          state_nxt_s  = ST_HOLD;
          cnt_nxt_s    = CNT_ONE;
        end else begin
          jump_en_o       = 1'b1;
          jump_addr_o     = pend_addr_r;
          flush_if_id_o   = 1'b1;
          flush_id_ex_o   = 1'b1;
          pend_en_nxt_s   = 1'b0;
          pend_addr_nxt_s = 32'h0000_0000;
          state_nxt_s     = ST_RUN;
          cnt_nxt_s       = CNT_ZERO;
        end
      end

      default: begin
        // Unreachable encoding. Fall back to a clean restart.
        hold_pc_o       = 1'b1;
        flush_if_id_o   = 1'b1;
        flush_id_ex_o   = 1'b1;
        state_nxt_s     = ST_BOOT;
        cnt_nxt_s       = CNT_ZERO;
        pend_en_nxt_s   = 1'b0;
        pend_addr_nxt_s = 32'h0000_0000;
      end
    endcase
  end

endmodule
